ioblock_cfg_loader: RTL and testbench
=====================================

// Module: ioblock_cfg_loader
// PURPOSE
//  Serial configuration writer for the IO blocks. Receives a framed bitstream
//  on a valid/ready bit interface and decodes each frame into one IO block's
//  config fields: TSMUX[1:0] (pin drive mode) and DORREG (direct/registered input).
//  Holds the config of NUM_IO blocks and drives it as flat vectors, one slice per
//  IO block instance.
// PARAMETERS
//  NUM_IO     8      number of IO blocks configured (1..2**ADDR_W)
//  ADDR_W     3      address field width in frame bits
//  SYNC_WORD  8'hA5  frame start pattern, 8 bits
// PORTS
//  IOCLK           in   1         clock, all state on rising edge
//  RST             in   1         asynchronous, active-high reset
//  CFG_DIN         in   1         serial config bit
//  CFG_VALID       in   1         CFG_DIN valid this cycle
//  CFG_READY       out  1         loader accepts a bit this cycle
//  CFG_TSMUX_VEC   out  2*NUM_IO  TSMUX of IO i at [2i+1:2i]
//  CFG_DORREG_VEC  out  NUM_IO    DORREG of IO i at [i]
//  CFG_BUSY        out  1         frame in progress (sync matched, not yet written/dropped)
//  CFG_DONE        out  1         1-cycle pulse: a frame was committed
//  CFG_ERR         out  1         1-cycle pulse: a frame was dropped
// BEHAVIOUR
//  - Bit accepted on a rising edge when CFG_VALID && CFG_READY. MSB first.
//  - Frame: SYNC_WORD(8) | ADDR(ADDR_W) | TSMUX[1] | TSMUX[0] | DORREG | [PAR].
//  - FSM: HUNT -> ADDR -> DATA -> (PAR) -> COMMIT -> HUNT.
//    HUNT: 8-bit shift reg of accepted bits; matching SYNC_WORD -> ADDR. Counter clears.
//    ADDR: ADDR_W bits, then DATA. DATA: 3 bits, then PAR (macro on) or COMMIT.
//    COMMIT: one cycle, CFG_READY=0. Writes slice ADDR, pulses CFG_DONE, -> HUNT.
//  - Latency: last frame bit accepted at edge k. Vectors update and CFG_DONE=1
//    at edge k+1. CFG_READY=1 again after edge k+1.
//  - ADDR >= NUM_IO: frame fully consumed. In COMMIT no write, CFG_ERR pulses
//    instead of CFG_DONE.
//  - CFG_VALID=0 mid-frame: state and counters hold. No timeout.
//  - HUNT shift reg clears on COMMIT entry, so frames need a full fresh SYNC_WORD.
//    Overlapping sync inside the payload is not searched.
//  - CFG_BUSY = 1 in ADDR, DATA, PAR and COMMIT states.
//  - Reset (any time, incl. mid-frame): state HUNT, shift reg 0, CFG_READY=1,
//    CFG_TSMUX_VEC=0 (all pins tristated), CFG_DORREG_VEC=0, BUSY/DONE/ERR=0.
//  - Rewriting an address replaces that slice only. Other slices unchanged.
// CONFIGURATION
//  - IOBLOCK_CFG_PARITY_EN defined:
//    - frame carries PAR = even parity over ADDR+data bits (XOR of all those
//      bits and PAR equals 0);
//    - mismatch -> no write, CFG_ERR pulse in COMMIT;
//    - frame length 8+ADDR_W+4.
//  - Not defined: no PAR state; frame length 8+ADDR_W+3; CFG_ERR only on bad address.
// STRUCTURE
//  - Shared package (ioblock_cfg_pkg):
//    - state encoding HUNT/ADDR/DATA/PAR/COMMIT;
//    - TSMUX codes: 2'b00 tristate, 2'b01 TS-gated, 2'b1x always drive;
//    - DORREG codes: 0 direct, 1 registered;
//    - default SYNC_WORD.
//  - One sub-module: cfg_frame_rx (sync hunt + FSM + field capture). Outputs a
//    commit strobe with addr/tsmux/dorreg/ok. The top level holds the
//    config register file.
// TESTING
//  1. Reset, then 16 idle cycles -> TSMUX_VEC=0, DORREG_VEC=0, READY=1,
//     BUSY/DONE/ERR=0.
//  2. Stream A5, addr 3, data 3'b011 (+PAR 0 when macro on), VALID held 1 ->
//     DONE pulses 1 cycle after last bit; TSMUX_VEC[7:6]=01; DORREG_VEC[3]=1;
//     rest 0.
//  3. Same frame with VALID dropped for 5 cycles after the addr bits -> same
//     result; BUSY stays 1 through the gap.
//  4. NUM_IO=6, frame to addr 7 -> ERR pulse, vectors unchanged; next valid frame
//     to addr 0 commits.
//  5. Macro on, frame with flipped PAR -> ERR, no write. Macro off, same
//     bit count -> extra bit lands in HUNT, frame commits.
//  6. RST asserted mid-DATA after earlier commits -> all vectors 0, state HUNT;
//     a fresh full frame after release commits.

Source files
------------

// File: rtl/ioblock_cfg_pkg.sv
// Shared definitions for the IO block configuration loader.
//   - Frame receiver FSM state encoding (HUNT/ADDR/DATA/PAR/COMMIT).
//   - TSMUX and DORREG code points for one IO block.
//   - Default frame sync word.
//   - io_cfg_t: the config fields carried by one frame.
package ioblock_cfg_pkg;

  localparam logic [2:0] StHunt   = 3'd0;
  localparam logic [2:0] StAddr   = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StPar    = 3'd3;
  localparam logic [2:0] StCommit = 3'd4;

  // TSMUX codes; any value with bit 1 set means always drive.
  localparam logic [1:0] TsmuxTristate = 2'b00;
  localparam logic [1:0] TsmuxTsGated  = 2'b01;
  localparam logic [1:0] TsmuxDrive    = 2'b10;

  localparam logic DorregDirect     = 1'b0;
  localparam logic DorregRegistered = 1'b1;

  localparam logic [7:0] DefaultSyncWord = 8'hA5;

  typedef struct packed {
    logic [1:0] tsmux;
    logic       dorreg;
  } io_cfg_t;

endpackage

// File: rtl/ioblock_cfg_loader_if.sv
// Bit-serial config input and decoded config outputs of the IO block loader.
//   CFG_DIN/CFG_VALID/CFG_READY : valid/ready bit stream, MSB first
//   CFG_TSMUX_VEC               : TSMUX of IO i at [2i+1:2i]
//   CFG_DORREG_VEC              : DORREG of IO i at [i]
//   CFG_BUSY/CFG_DONE/CFG_ERR   : frame in progress / commit pulse / drop pulse
// master: the bitstream source; slave: the loader.
interface ioblock_cfg_loader_if #(
  parameter int unsigned NUM_IO = 8
);
  logic                  CFG_DIN;
  logic                  CFG_VALID;
  logic                  CFG_READY;
  logic [2*NUM_IO-1:0]   CFG_TSMUX_VEC;
  logic [NUM_IO-1:0]     CFG_DORREG_VEC;
  logic                  CFG_BUSY;
  logic                  CFG_DONE;
  logic                  CFG_ERR;

  modport master (
    output CFG_DIN, CFG_VALID,
    input  CFG_READY, CFG_TSMUX_VEC, CFG_DORREG_VEC, CFG_BUSY, CFG_DONE, CFG_ERR
  );

  modport slave (
    input  CFG_DIN, CFG_VALID,
    output CFG_READY, CFG_TSMUX_VEC, CFG_DORREG_VEC, CFG_BUSY, CFG_DONE, CFG_ERR
  );
endinterface

// File: rtl/cfg_frame_rx.sv
// Frame receiver: hunts for the sync word in the accepted bit stream, then
// captures ADDR, TSMUX[1], TSMUX[0], DORREG (and PAR when IOBLOCK_CFG_PARITY_EN
// is defined) and presents them for one COMMIT cycle.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_din, i_valid      serial bit and its valid
//   o_ready             bit accepted this cycle when i_valid is high
//   o_busy              sync matched, frame not yet committed/dropped
//   o_commit            high for the single COMMIT cycle
//   o_ok                frame may be written (address in range, parity good)
//   o_addr, o_cfg       captured address and config fields
// Macro IOBLOCK_CFG_PARITY_EN adds an even-parity bit after the data bits.
module cfg_frame_rx
  import ioblock_cfg_pkg::*;
#(
  parameter int unsigned NUM_IO    = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter logic [7:0]  SYNC_WORD = DefaultSyncWord
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_din,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_commit,
  output logic              o_ok,
  output logic [ADDR_W-1:0] o_addr,
  output io_cfg_t           o_cfg
);

`ifdef IOBLOCK_CFG_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  localparam int unsigned CntW = $clog2(ADDR_W + 3);

  logic [2:0]        r_state, w_state_d;
  logic [7:0]        r_shift, w_shift_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [2:0]        r_data, w_data_d;
  logic              r_par, w_par_d;
  logic              w_accept;
  logic [7:0]        w_shift_nxt;
  logic              w_addr_ok;

  assign w_accept    = i_valid && o_ready;
  assign w_shift_nxt = {r_shift[6:0], i_din};

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_cnt_d   = r_cnt;
    w_addr_d  = r_addr;
    w_data_d  = r_data;
    w_par_d   = r_par;
    unique case (r_state)
      StHunt: begin
        if (w_accept) begin
          w_shift_d = w_shift_nxt;
          if (w_shift_nxt == SYNC_WORD) begin
            w_state_d = StAddr;
            w_cnt_d   = '0;
            w_par_d   = 1'b0;
          end
        end
      end
      StAddr: begin
        if (w_accept) begin
          w_addr_d = (r_addr << 1) | ADDR_W'(i_din);
          w_par_d  = r_par ^ i_din;
          w_cnt_d  = r_cnt + CntW'(1);
          if (r_cnt == CntW'(ADDR_W - 1)) begin
            w_state_d = StData;
            w_cnt_d   = '0;
          end
        end
      end
      StData: begin
        if (w_accept) begin
          w_data_d = {r_data[1:0], i_din};
          w_par_d  = r_par ^ i_din;
          w_cnt_d  = r_cnt + CntW'(1);
          if (r_cnt == CntW'(2)) begin
            w_cnt_d = '0;
            if (ParityEn) begin
              w_state_d = StPar;
            end else begin
              w_state_d = StCommit;
              // Sync search restarts from scratch after every frame.
              w_shift_d = '0;
            end
          end
        end
      end
      StPar: begin
        if (w_accept) begin
          w_par_d   = r_par ^ i_din;
          w_state_d = StCommit;
          w_shift_d = '0;
        end
      end
      StCommit: w_state_d = StHunt;
      default:  w_state_d = StHunt;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StHunt;
      r_shift <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_cnt   <= w_cnt_d;
      r_addr  <= w_addr_d;
      r_data  <= w_data_d;
      r_par   <= w_par_d;
    end
  end

  assign w_addr_ok   = ({1'b0, r_addr} < (ADDR_W + 1)'(NUM_IO));
  assign o_ready     = (r_state != StCommit);
  assign o_busy      = (r_state != StHunt);
  assign o_commit    = (r_state == StCommit);
  // r_par holds the XOR of ADDR, data and PAR bits; zero means even parity.
  assign o_ok        = w_addr_ok && (!ParityEn || !r_par);
  assign o_addr      = r_addr;
  assign o_cfg.tsmux  = r_data[2:1];
  assign o_cfg.dorreg = r_data[0];

endmodule

// File: rtl/ioblock_cfg_loader.sv
// IO block configuration loader top level. Receives framed config bits through
// cfg (slave modport), decodes them with cfg_frame_rx and holds the TSMUX and
// DORREG config of NUM_IO IO blocks as flat vectors.
// Ports:
//   IOCLK  clock, all state on rising edge
//   RST    asynchronous active-high reset; clears all config (pins tristated)
//   cfg    bit stream in, config vectors and BUSY/DONE/ERR status out
// Macro IOBLOCK_CFG_PARITY_EN (handled in cfg_frame_rx) enables frame parity.
module ioblock_cfg_loader
  import ioblock_cfg_pkg::*;
#(
  parameter int unsigned NUM_IO    = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter logic [7:0]  SYNC_WORD = DefaultSyncWord
) (
  input  logic                 IOCLK,
  input  logic                 RST,
  ioblock_cfg_loader_if.slave  cfg
);

  logic [2*NUM_IO-1:0] r_tsmux;
  logic [NUM_IO-1:0]   r_dorreg;
  logic                r_done;
  logic                r_err;

  logic                w_ready;
  logic                w_busy;
  logic                w_commit;
  logic                w_ok;
  logic [ADDR_W-1:0]   w_addr;
  io_cfg_t             w_cfg;

  cfg_frame_rx #(
    .NUM_IO    (NUM_IO),
    .ADDR_W    (ADDR_W),
    .SYNC_WORD (SYNC_WORD)
  ) u_frame_rx (
    .i_clk    (IOCLK),
    .i_rst    (RST),
    .i_din    (cfg.CFG_DIN),
    .i_valid  (cfg.CFG_VALID),
    .o_ready  (w_ready),
    .o_busy   (w_busy),
    .o_commit (w_commit),
    .o_ok     (w_ok),
    .o_addr   (w_addr),
    .o_cfg    (w_cfg)
  );

  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      r_tsmux  <= '0;
      r_dorreg <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_commit && w_ok;
      r_err  <= w_commit && !w_ok;
      if (w_commit && w_ok) begin
        for (int i = 0; i < int'(NUM_IO); i++) begin
          if (w_addr == ADDR_W'(i)) begin
            r_tsmux[2*i +: 2] <= w_cfg.tsmux;
            r_dorreg[i]       <= w_cfg.dorreg;
          end
        end
      end
    end
  end

  assign cfg.CFG_READY      = w_ready;
  assign cfg.CFG_BUSY       = w_busy;
  assign cfg.CFG_DONE       = r_done;
  assign cfg.CFG_ERR        = r_err;
  assign cfg.CFG_TSMUX_VEC  = r_tsmux;
  assign cfg.CFG_DORREG_VEC = r_dorreg;

endmodule

// File: tb/tb_ioblock_cfg_loader.sv
// Bench for ioblock_cfg_loader with NUM_IO=6, ADDR_W=3 so that addresses 6 and
// 7 are out of range. Expected config is kept as per-IO arrays and updated from
// the frame rules; vectors are rebuilt from those arrays for comparison.
module tb_ioblock_cfg_loader;
  localparam int unsigned NUM_IO = 6;
  localparam int unsigned ADDR_W = 3;

  logic IOCLK = 1'b0;
  logic RST   = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] m_ts [NUM_IO];
  logic       m_dr [NUM_IO];

  ioblock_cfg_loader_if #(.NUM_IO(NUM_IO)) cfg_if ();

  ioblock_cfg_loader #(
    .NUM_IO    (NUM_IO),
    .ADDR_W    (ADDR_W),
    .SYNC_WORD (8'hA5)
  ) dut (
    .IOCLK (IOCLK),
    .RST   (RST),
    .cfg   (cfg_if)
  );

  always #5 IOCLK = ~IOCLK;

  function automatic logic [2*NUM_IO-1:0] exp_ts_vec();
    logic [2*NUM_IO-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NUM_IO); i++) v[2*i +: 2] = m_ts[i];
    return v;
  endfunction

  function automatic logic [NUM_IO-1:0] exp_dr_vec();
    logic [NUM_IO-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NUM_IO); i++) v[i] = m_dr[i];
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < int'(NUM_IO); i++) begin
      m_ts[i] = 2'b00;
      m_dr[i] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    cfg_if.CFG_VALID = 1'b0;
    repeat (n) begin
      @(posedge IOCLK);
      #1;
    end
  endtask

  // Presents one bit and returns 1 time unit after the edge that accepted it.
  task automatic drive_bit(input logic b, input string nm);
    int guard;
    cfg_if.CFG_DIN   = b;
    cfg_if.CFG_VALID = 1'b1;
    guard = 0;
    while (cfg_if.CFG_READY !== 1'b1 && guard < 8) begin
      @(posedge IOCLK);
      #1;
      guard++;
    end
    checks++;
    if (guard >= 8) begin
      errors++;
      $display("FAIL %s ready_timeout: ready=%b required 1 within 8 cycles", nm, cfg_if.CFG_READY);
    end
    @(posedge IOCLK);
    #1;
    cfg_if.CFG_VALID = 1'b0;
  endtask

  task automatic send_sync_addr(input logic [ADDR_W-1:0] a, input int rgap, input string nm);
    logic [7:0] sync;
    sync = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      if (rgap > 0) idle($urandom_range(0, rgap));
      drive_bit(sync[i], nm);
    end
    for (int i = int'(ADDR_W) - 1; i >= 0; i--) begin
      if (rgap > 0) idle($urandom_range(0, rgap));
      drive_bit(a[i], nm);
    end
  endtask

  // Sends a full frame and checks the commit/drop outcome against the model.
  task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [2:0] d, input bit flip,
                            input int gap, input int rgap, input string nm);
    bit ok;
    send_sync_addr(a, rgap, nm);
    for (int g = 0; g < gap; g++) begin
      idle(1);
      checks++;
      if (cfg_if.CFG_BUSY !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_gap: busy=%b required 1", nm, cfg_if.CFG_BUSY);
      end
    end
    for (int i = 2; i >= 0; i--) begin
      if (rgap > 0) idle($urandom_range(0, rgap));
      drive_bit(d[i], nm);
    end
`ifdef IOBLOCK_CFG_PARITY_EN
    if (rgap > 0) idle($urandom_range(0, rgap));
    drive_bit((^{a, d}) ^ flip, nm);
    ok = (int'(a) < int'(NUM_IO)) && !flip;
`else
    ok = (int'(a) < int'(NUM_IO));
`endif
    // COMMIT cycle
    checks++;
    if (cfg_if.CFG_READY !== 1'b0 || cfg_if.CFG_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL %s commit_cycle: ready=%b busy=%b required ready=0 busy=1", nm,
               cfg_if.CFG_READY, cfg_if.CFG_BUSY);
    end
    checks++;
    if (cfg_if.CFG_DONE !== 1'b0 || cfg_if.CFG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL %s early_pulse: done=%b err=%b required 0 0", nm, cfg_if.CFG_DONE,
               cfg_if.CFG_ERR);
    end
    if (ok) begin
      m_ts[a] = d[2:1];
      m_dr[a] = d[0];
    end
    @(posedge IOCLK);
    #1;
    checks++;
    if (cfg_if.CFG_DONE !== ok || cfg_if.CFG_ERR !== !ok) begin
      errors++;
      $display("FAIL %s outcome: done=%b err=%b required done=%b err=%b", nm, cfg_if.CFG_DONE,
               cfg_if.CFG_ERR, ok, !ok);
    end
    checks++;
    if (cfg_if.CFG_READY !== 1'b1 || cfg_if.CFG_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s after_commit: ready=%b busy=%b required ready=1 busy=0", nm,
               cfg_if.CFG_READY, cfg_if.CFG_BUSY);
    end
    checks++;
    if (cfg_if.CFG_TSMUX_VEC !== exp_ts_vec()) begin
      errors++;
      $display("FAIL %s tsmux_vec: got %h required %h", nm, cfg_if.CFG_TSMUX_VEC, exp_ts_vec());
    end
    checks++;
    if (cfg_if.CFG_DORREG_VEC !== exp_dr_vec()) begin
      errors++;
      $display("FAIL %s dorreg_vec: got %b required %b", nm, cfg_if.CFG_DORREG_VEC,
               exp_dr_vec());
    end
    @(posedge IOCLK);
    #1;
    checks++;
    if (cfg_if.CFG_DONE !== 1'b0 || cfg_if.CFG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_len: done=%b err=%b required 0 0", nm, cfg_if.CFG_DONE,
               cfg_if.CFG_ERR);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cfg_if.CFG_DIN   = 1'b0;
    cfg_if.CFG_VALID = 1'b0;
    clear_model();
    repeat (3) @(posedge IOCLK);
    #2;
    RST = 1'b0;
    repeat (16) @(posedge IOCLK);
    #1;
    checks++;
    if (cfg_if.CFG_TSMUX_VEC !== '0 || cfg_if.CFG_DORREG_VEC !== '0) begin
      errors++;
      $display("FAIL reset vectors: tsmux=%h dorreg=%b required 0 0", cfg_if.CFG_TSMUX_VEC,
               cfg_if.CFG_DORREG_VEC);
    end
    checks++;
    if (cfg_if.CFG_READY !== 1'b1 || cfg_if.CFG_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset status: ready=%b busy=%b required 1 0", cfg_if.CFG_READY,
               cfg_if.CFG_BUSY);
    end
    checks++;
    if (cfg_if.CFG_DONE !== 1'b0 || cfg_if.CFG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset pulses: done=%b err=%b required 0 0", cfg_if.CFG_DONE, cfg_if.CFG_ERR);
    end
  endtask

  task automatic test_basic();
    send_frame(3'd3, 3'b011, 1'b0, 0, 0, "basic");
    checks++;
    if (cfg_if.CFG_TSMUX_VEC !== 12'h040 || cfg_if.CFG_DORREG_VEC !== 6'b001000) begin
      errors++;
      $display("FAIL basic literal: tsmux=%h dorreg=%b required 040 001000",
               cfg_if.CFG_TSMUX_VEC, cfg_if.CFG_DORREG_VEC);
    end
  endtask

  task automatic test_valid_gap();
    send_frame(3'd3, 3'b011, 1'b0, 5, 0, "valid_gap");
    send_frame(3'd5, 3'b100, 1'b0, 3, 0, "valid_gap5");
  endtask

  task automatic test_bad_addr();
    send_frame(3'd7, 3'b111, 1'b0, 0, 0, "bad_addr7");
    send_frame(3'd6, 3'b101, 1'b0, 0, 0, "bad_addr6");
    send_frame(3'd0, 3'b110, 1'b0, 0, 0, "addr0_after_bad");
  endtask

  task automatic test_parity();
`ifdef IOBLOCK_CFG_PARITY_EN
    send_frame(3'd2, 3'b101, 1'b1, 0, 0, "par_flip");
    send_frame(3'd2, 3'b101, 1'b0, 0, 0, "par_good");
`else
    send_frame(3'd2, 3'b101, 1'b0, 0, 0, "no_par_frame");
    drive_bit(1'b1, "no_par_extra");
    idle(2);
    checks++;
    if (cfg_if.CFG_BUSY !== 1'b0 || cfg_if.CFG_READY !== 1'b1 || cfg_if.CFG_DONE !== 1'b0 ||
        cfg_if.CFG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL no_par_extra status: busy=%b ready=%b done=%b err=%b required 0 1 0 0",
               cfg_if.CFG_BUSY, cfg_if.CFG_READY, cfg_if.CFG_DONE, cfg_if.CFG_ERR);
    end
    checks++;
    if (cfg_if.CFG_TSMUX_VEC !== exp_ts_vec() || cfg_if.CFG_DORREG_VEC !== exp_dr_vec()) begin
      errors++;
      $display("FAIL no_par_extra vectors: tsmux=%h dorreg=%b required %h %b",
               cfg_if.CFG_TSMUX_VEC, cfg_if.CFG_DORREG_VEC, exp_ts_vec(), exp_dr_vec());
    end
    send_frame(3'd4, 3'b010, 1'b0, 0, 0, "after_extra");
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [ADDR_W-1:0] a;
      logic [2:0]        d;
      bit                flip;
      a    = ADDR_W'($urandom_range(0, 7));
      d    = 3'($urandom_range(0, 7));
      flip = 1'b0;
`ifdef IOBLOCK_CFG_PARITY_EN
      flip = ($urandom_range(0, 3) == 0);
`endif
      send_frame(a, d, flip, 0, n % 3, "random");
    end
  endtask

  task automatic test_reset_mid();
    send_frame(3'd1, 3'b111, 1'b0, 0, 0, "pre_rst1");
    send_frame(3'd4, 3'b001, 1'b0, 0, 0, "pre_rst4");
    send_sync_addr(3'd2, 0, "mid_rst");
    drive_bit(1'b1, "mid_rst");
    #2;
    RST = 1'b1;
    clear_model();
    #1;
    checks++;
    if (cfg_if.CFG_TSMUX_VEC !== '0 || cfg_if.CFG_DORREG_VEC !== '0) begin
      errors++;
      $display("FAIL mid_rst vectors: tsmux=%h dorreg=%b required 0 0", cfg_if.CFG_TSMUX_VEC,
               cfg_if.CFG_DORREG_VEC);
    end
    checks++;
    if (cfg_if.CFG_BUSY !== 1'b0 || cfg_if.CFG_READY !== 1'b1 || cfg_if.CFG_DONE !== 1'b0 ||
        cfg_if.CFG_ERR !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst status: busy=%b ready=%b done=%b err=%b required 0 1 0 0",
               cfg_if.CFG_BUSY, cfg_if.CFG_READY, cfg_if.CFG_DONE, cfg_if.CFG_ERR);
    end
    @(posedge IOCLK);
    #1;
    RST = 1'b0;
    idle(2);
    send_frame(3'd2, 3'b011, 1'b0, 0, 0, "post_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_valid_gap();
    test_bad_addr();
    test_parity();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
